// File: rtl/ram_write_sequencer_if.sv
// ram_write_sequencer_if: producer handshake, clear control, RAM write port and status of the write sequencer
interface ram_write_sequencer_if #(parameter int ADDR_W = 5, parameter int DATA_W = 4);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              clear_req;
    logic [DATA_W-1:0] fill_value;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              busy;
    modport master (output in_valid, in_data, clear_req, fill_value,
                    input in_ready, wr_en, wr_addr, wr_data, count, full, busy);
    modport slave (input in_valid, in_data, clear_req, fill_value,
                   output in_ready, wr_en, wr_addr, wr_data, count, full, busy);
endinterface

// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer: streams words into consecutive RAM addresses and bulk-fills the RAM on request.
// Define RAM_WRITE_SEQ_WRAP_EN for circular overwrite instead of stopping when full.
module ram_write_sequencer #(parameter int ADDR_W = 5, parameter int DATA_W = 4) (
    input logic clk,
    input logic aclr,
    ram_write_sequencer_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
    typedef enum logic {ACCEPT, CLEAR} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx, wr_addr, wr_addr_nx;
    logic [ADDR_W:0] count, count_nx;
    logic [DATA_W-1:0] wr_data, wr_data_nx;
    logic wr_en, wr_en_nx, xfer;
`ifdef RAM_WRITE_SEQ_WRAP_EN
    assign bus.full = 1'b0;
    assign bus.in_ready = state == ACCEPT && !bus.clear_req;
`else
    assign bus.full = count == DEPTH;
    assign bus.in_ready = state == ACCEPT && !bus.full && !bus.clear_req;
`endif
    assign bus.busy = state == CLEAR;
    assign bus.count = count;
    assign bus.wr_en = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign xfer = bus.in_valid && bus.in_ready;
    // ptr wraps naturally; the clear ends right after writing the all-ones address
    always_comb begin
        state_nx = state;
        ptr_nx = ptr;
        count_nx = count;
        wr_en_nx = 1'b0;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
        if (state == CLEAR) begin
            wr_en_nx = 1'b1;
            wr_addr_nx = ptr;
            wr_data_nx = bus.fill_value;
            ptr_nx = ptr + 1'b1;
            state_nx = &ptr ? ACCEPT : CLEAR;
            count_nx = &ptr ? '0 : count;
        end else if (bus.clear_req) begin
            state_nx = CLEAR;
            ptr_nx = '0;
        end else if (xfer) begin
            wr_en_nx = 1'b1;
            wr_addr_nx = ptr;
            wr_data_nx = bus.in_data;
            ptr_nx = ptr + 1'b1;
            count_nx = count == DEPTH ? count : count + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state <= ACCEPT;
            ptr <= '0;
            count <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            count <= count_nx;
            wr_en <= wr_en_nx;
            wr_addr <= wr_addr_nx;
            wr_data <= wr_data_nx;
        end
    end
endmodule

// File: tb/tb_ram_write_sequencer.sv
// tb_ram_write_sequencer: directed stimulus with a transaction-level model checked every falling edge
module tb_ram_write_sequencer;
    localparam int DEPTH = 32;
`ifdef RAM_WRITE_SEQ_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic aclr = 1'b0;
    int vectors = 0;
    int errors = 0;
    int m_x = 0;
    int m_clr = -1;
    int e_we = 0;
    int e_addr = 0;
    int e_data = 0;
    ram_write_sequencer_if #(.ADDR_W(5), .DATA_W(4)) bus ();
    ram_write_sequencer #(.ADDR_W(5), .DATA_W(4)) dut (.clk(clk), .aclr(aclr), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // model: ptr is transfers-since-clear mod DEPTH, count is that total capped at DEPTH
    always @(negedge clk) begin
        int e_cnt;
        int e_full;
        int e_ready;
        if (!aclr) begin
            m_x = 0;
            m_clr = -1;
            e_we = 0;
        end
        e_cnt = m_x > DEPTH ? DEPTH : m_x;
        e_full = (!WRAP && m_x >= DEPTH) ? 1 : 0;
        e_ready = (m_clr < 0 && !e_full && !bus.clear_req) ? 1 : 0;
        chk("m_wr_en", bus.wr_en, e_we);
        if (e_we != 0) begin
            chk("m_wr_addr", bus.wr_addr, e_addr);
            chk("m_wr_data", bus.wr_data, e_data);
        end
        chk("m_count", bus.count, e_cnt);
        chk("m_full", bus.full, e_full);
        chk("m_busy", bus.busy, m_clr >= 0 ? 1 : 0);
        chk("m_in_ready", bus.in_ready, e_ready);
        if (aclr) begin
            e_we = 0;
            if (m_clr >= 0) begin
                e_we = 1;
                e_addr = m_clr;
                e_data = bus.fill_value;
                m_clr++;
                if (m_clr == DEPTH) begin
                    m_clr = -1;
                    m_x = 0;
                end
            end else if (bus.clear_req) begin
                m_clr = 0;
            end else if (bus.in_valid && e_ready != 0) begin
                e_we = 1;
                e_addr = m_x % DEPTH;
                e_data = bus.in_data;
                m_x++;
            end
        end
    end
    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.clear_req = 1'b0;
        bus.fill_value = '0;
        tick;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        tick;
        aclr = 1'b1;
        tick;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h3;
        tick;
        chk("t1_we0", bus.wr_en, 1);
        chk("t1_addr0", bus.wr_addr, 0);
        chk("t1_data0", bus.wr_data, 3);
        bus.in_data = 4'h7;
        tick;
        bus.in_data = 4'hA;
        tick;
        chk("t1_addr2", bus.wr_addr, 2);
        chk("t1_data2", bus.wr_data, 10);
        bus.in_valid = 1'b0;
        tick;
        chk("t1_we_off", bus.wr_en, 0);
        chk("t1_count", bus.count, 3);
        aclr = 1'b0;
        tick;
        aclr = 1'b1;
        tick;
        for (int i = 0; i < (WRAP ? 34 : 33); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 4'(i);
            tick;
            if (i == 31) chk("t2_last_addr", bus.wr_addr, 31);
            if (WRAP && i == 32) chk("t2_wrap_addr0", bus.wr_addr, 0);
        end
        if (WRAP) begin
            chk("t2_wrap_addr1", bus.wr_addr, 1);
            chk("t2_wrap_we", bus.wr_en, 1);
        end else begin
            chk("t2_no_33rd", bus.wr_en, 0);
            chk("t2_ready", bus.in_ready, 0);
        end
        chk("t2_count", bus.count, 32);
        chk("t2_full", bus.full, WRAP ? 0 : 1);
        bus.in_valid = 1'b0;
        bus.clear_req = 1'b1;
        bus.fill_value = 4'hF;
        tick;
        chk("t3_busy", bus.busy, 1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            bus.clear_req = (k == 5);
            tick;
            if (bus.wr_en) begin
                chk("t3_addr", bus.wr_addr, n);
                chk("t3_data", bus.wr_data, 15);
                n++;
            end
        end
        chk("t3_writes", n, 32);
        chk("t3_busy_off", bus.busy, 0);
        chk("t3_full_off", bus.full, 0);
        chk("t3_count", bus.count, 0);
        chk("t3_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data = 4'h1;
        tick;
        bus.in_data = 4'h2;
        tick;
        bus.in_data = 4'h9;
        bus.clear_req = 1'b1;
        bus.fill_value = 4'h5;
        #1;
        chk("t4_ready", bus.in_ready, 0);
        tick;
        bus.clear_req = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_no_write", bus.wr_en, 0);
        chk("t4_count", bus.count, 2);
        tick;
        chk("t4_clr_addr0", bus.wr_addr, 0);
        chk("t4_clr_data", bus.wr_data, 5);
        for (int k = 1; k < 10; k++) tick;
        chk("t5_addr9", bus.wr_addr, 9);
        #2;
        aclr = 1'b0;
        #1;
        chk("t5_we_async", bus.wr_en, 0);
        chk("t5_busy_async", bus.busy, 0);
        chk("t5_count_async", bus.count, 0);
        chk("t5_addr_async", bus.wr_addr, 0);
        tick;
        aclr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h6;
        tick;
        chk("t5_first_addr", bus.wr_addr, 0);
        chk("t5_first_data", bus.wr_data, 6);
        bus.in_valid = 1'b0;
        tick;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ram_write_sequencer.md
Name: ram_write_sequencer

Overview:
- Write-side controller for the 32x4 dual-port RAM.
- Accepts a stream of data words over a valid/ready handshake and writes them to consecutive addresses starting at 0. A read-side scanner sweeps the same addresses.
- Also provides a bulk clear that fills every location with a programmable value.
- Drives the RAM write port (we, wraddress, data) directly. A fill count is provided for the HEX displays.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W locations
DATA_W, 4, data word width

Ports:
clk  input  1  clock, rising edge
aclr  input  1  asynchronous reset, active-low
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_W  word to store
in_ready  output  1  sequencer can accept a word this cycle
clear_req  input  1  request bulk fill, sampled on clk
fill_value  input  DATA_W  word written to every location during clear
wr_en  output  1  RAM write enable (registered)
wr_addr  output  ADDR_W  RAM write address (registered)
wr_data  output  DATA_W  RAM write data (registered)
count  output  ADDR_W+1  number of words stored since last clear/reset, 0..DEPTH
full  output  1  count == DEPTH
busy  output  1  clear in progress

Behaviour:
- Reset is decided: aclr, asynchronous, active-low; clock clk.
- Reset values: state=ACCEPT, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, busy=0. Internal pointer ptr=0.
- States:
  - ACCEPT: normal streaming.
  - CLEAR: bulk fill.
- Handshake:
  - in_ready = (state==ACCEPT) && !full && !clear_req. This is combinational from state, full and clear_req.
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_data is not captured while in_ready=0. The producer holds in_valid and in_data until in_ready.
- Write on a transfer (1-cycle latency): on the next edge wr_en=1, wr_addr=ptr, wr_data=in_data. Then ptr advances by 1 and count advances by 1.
- wr_en is high for exactly one cycle per transfer. Back-to-back transfers give wr_en high every cycle with consecutive addresses.
- Full: when count reaches DEPTH, full=1 and in_ready=0. ptr wraps to 0 but no further writes occur. full stays 1 until a clear or reset.
- clear_req while in ACCEPT: transition to CLEAR on the next edge, with busy=1 and ptr=0.
- In CLEAR:
  - Each cycle: wr_en=1, wr_addr=ptr, wr_data=fill_value (sampled each cycle), ptr++.
  - After the write to DEPTH-1: return to ACCEPT with busy=0, ptr=0, count=0, full=0.
  - Duration is exactly DEPTH cycles of wr_en.
- Simultaneous clear_req and in_valid: clear wins. in_ready=0, so no transfer occurs.
- clear_req during CLEAR is ignored; the clear is not restarted.
- clear_req while full is allowed.
- aclr asserted mid-clear or mid-stream: all state returns to reset values immediately, and wr_en drops asynchronously. RAM contents already written are left as they are.
- count arithmetic is ADDR_W+1 bits so that DEPTH can be represented. ptr is ADDR_W bits and wraps modulo DEPTH.

Optional Feature:
- Macro: RAM_WRITE_SEQ_WRAP_EN.
- Defined (circular mode):
  - full is tied to 0.
  - in_ready = (state==ACCEPT) && !clear_req.
  - ptr wraps from DEPTH-1 to 0 and overwrites the oldest data.
  - count saturates at DEPTH.
- Not defined: full and stop behaviour as described under Behaviour.

Test Plan:
- Reset, then in_valid=1 with in_data=3,7,A on 3 consecutive cycles -> wr_en high for 3 cycles starting 1 cycle later, wr_addr=0,1,2, wr_data=3,7,A, count=3.
- 32 back-to-back transfers of data=addr[3:0] -> final write at wr_addr=31, then full=1, count=32, in_ready=0. A 33rd in_valid produces no wr_en.
- From full, pulse clear_req with fill_value=F -> busy=1, wr_en high for exactly 32 cycles, addresses 0..31 with data F. Then busy=0, full=0, count=0, in_ready=1.
- clear_req and in_valid asserted in the same cycle -> in_ready=0, no stream write. Clear sequence starts at wr_addr=0.
- Assert aclr low at the 10th cycle of a clear -> wr_en=0, busy=0, count=0, wr_addr=0 immediately. After release, the first transfer writes address 0.
- With RAM_WRITE_SEQ_WRAP_EN defined, perform 34 transfers -> 33rd and 34th writes go to wr_addr=0,1. full stays 0, count=32.
